sdram_arb: RTL
==============

Name: sdram_arb

Overview:
- Multi-port arbiter that shares the single-command tiny SDRAM controller between N requesters, e.g. CPU bus, CD-block DMA and cartridge bus.
- Accepts one command at a time from the winning port and holds it stable until the controller acknowledges.
- Routes the 4-word read burst back to the granting port only.
- Sits directly on the controller's cmd_* / data_valid side; refresh scheduling stays inside the controller.

Parameters:
- NPORT, 3, number of requester ports (2..4).
- BL, 4, read burst length in words; must match the controller's burst length.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- p_req  input  2*NPORT  per-port command, port i in [2i+1:2i]: 00 nop, 01 write byte, 11 write word, 10 read word.
- p_ack  output  NPORT  one-cycle accept pulse per port.
- p_mask  input  2*NPORT  per-port byte mask (DQM), port i in [2i+1:2i].
- p_addr  input  32*NPORT  per-port byte address, port i in [32i+31:32i].
- p_din  input  16*NPORT  per-port write data.
- p_dout  output  16  read data, broadcast to all ports.
- p_valid  output  NPORT  read data valid, granted port only.
- m_req  output  2  command to controller (cmd_req).
- m_ack  input  1  controller accept (cmd_ack), one-cycle pulse.
- m_mask  output  2  to cmd_mask.
- m_addr  output  32  to cmd_addr.
- m_din  output  16  to cmd_din.
- m_dout  input  16  from cmd_dout.
- m_valid  input  1  from data_valid.

Behaviour:
- Reset values: state=IDLE, gnt=0, last=NPORT-1, rd_cnt=0, m_req=00, m_mask=11, m_addr=0, m_din=0, p_ack=0, p_valid=0.
- State machine: IDLE, ISSUE, RDATA.
- IDLE:
  - If any port has p_req!=00, select the winner (fixed priority: lowest index wins).
  - On the same edge, register gnt, m_req, m_mask, m_addr and m_din from the winner's slice, and go to ISSUE.
  - Otherwise hold m_req=00.
- ISSUE:
  - m_req, m_addr, m_mask and m_din stay frozen at the latched values. The controller samples the address in both ACTIVE and READ/WRITE, so stability is mandatory.
  - Changes on p_* for any port, including withdrawal by the granted port, are ignored; the latched command always completes.
  - p_ack[gnt] = m_ack while in ISSUE (combinational); all other bits are 0.
  - On m_ack: m_req<=00 and last<=gnt. If the latched command was a read (10), go to RDATA with rd_cnt=0; otherwise go to IDLE.
- Requester rule: hold p_req and operands until p_ack is sampled high, then drive p_req=00 on that same edge. The arbiter's next IDLE cycle therefore never re-sees a stale request.
- RDATA:
  - p_dout = m_dout (combinational).
  - p_valid[gnt] = m_valid; all other bits are 0.
  - Each cycle with m_valid: rd_cnt<=rd_cnt+1. When m_valid and rd_cnt==BL-1, go to IDLE.
  - No new command is issued until the burst completes.
  - m_valid high outside RDATA is ignored: p_valid stays 0.
- Latency: request visible in IDLE -> m_req asserted next cycle. After a write ack the next arbitration happens 1 cycle later; after a read, 1 cycle after the last valid word.
- Async reset mid-operation: immediately return to reset values; the pending command is dropped. The controller is reset by the same signal.

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at last+1 modulo NPORT, so the most recently served port has lowest priority next time.
- Not defined: fixed priority, port 0 highest. The `last` register may be optimised away.

Test Plan:
- Word write: port 1 with p_req=11, addr 0x00001000, din 0xA55A, mask 00. Expect m_req=11, m_addr=0x00001000, m_din=0xA55A, held until m_ack; p_ack=010 for exactly 1 cycle; p_valid stays 0.
- Byte write mask passthrough: port 2 with p_req=01, mask 01. Expect m_req=01 and m_mask=01, stable until ack.
- Read: port 0 with p_req=10, model returns m_valid for 4 cycles with data 0x0001..0x0004 starting 2 cycles after ack. Expect p_valid=001 for exactly 4 cycles with p_dout 1,2,3,4; then IDLE.
- Simultaneous requests: all 3 ports request reads continuously, each re-requesting after its ack.
  - Without SDRAM_ARB_RR_EN: grant order 0,0,0.
  - With SDRAM_ARB_RR_EN: grant order 0,1,2,0.
- Withdrawal: port 2 drops p_req during ISSUE. The latched command still completes and p_ack[2] pulses once.
- Reset mid-read: assert reset after the 2nd valid word. All outputs return to reset values asynchronously; after release, a port 1 write is served normally.

Source files
------------

// File: rtl/sdram_arb_if.sv
// Requester + controller bus bundle for sdram_arb. The arbiter uses the slave
// modport; the surrounding environment (requesters and controller) uses master.
interface sdram_arb_if #(
  parameter int NPORT = 3
);
  logic [2*NPORT-1:0]  p_req;
  logic [NPORT-1:0]    p_ack;
  logic [2*NPORT-1:0]  p_mask;
  logic [32*NPORT-1:0] p_addr;
  logic [16*NPORT-1:0] p_din;
  logic [15:0]         p_dout;
  logic [NPORT-1:0]    p_valid;

  logic [1:0]          m_req;
  logic                m_ack;
  logic [1:0]          m_mask;
  logic [31:0]         m_addr;
  logic [15:0]         m_din;
  logic [15:0]         m_dout;
  logic                m_valid;

  modport master (
    output p_req, p_mask, p_addr, p_din, m_ack, m_dout, m_valid,
    input  p_ack, p_dout, p_valid, m_req, m_mask, m_addr, m_din
  );

  modport slave (
    input  p_req, p_mask, p_addr, p_din, m_ack, m_dout, m_valid,
    output p_ack, p_dout, p_valid, m_req, m_mask, m_addr, m_din
  );
endinterface

// File: rtl/sdram_arb.sv
// N-port arbiter in front of the single-command SDRAM controller.
// Optional macro SDRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module sdram_arb #(
  parameter int NPORT = 3,
  parameter int BL    = 4
) (
  input  logic      clk,
  input  logic      reset,
  sdram_arb_if.slave bus
);

  localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = (BL > 1) ? $clog2(BL) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_e;

  state_e         state_q;
  logic [GW-1:0]  gnt_q;
  logic [CW-1:0]  rd_cnt_q;
  logic [1:0]     m_req_q;
  logic [1:0]     m_mask_q;
  logic [31:0]    m_addr_q;
  logic [15:0]    m_din_q;

  logic           any_req;
  logic [GW-1:0]  win;
  logic [1:0]     win_req;
  logic [1:0]     win_mask;
  logic [31:0]    win_addr;
  logic [15:0]    win_din;

`ifdef SDRAM_ARB_RR_EN
  logic [GW-1:0]  last_q;

  // Search starts just after the last served port so it ranks lowest next time.
  always_comb begin : sel_rr
    int unsigned idx;
    any_req  = 1'b0;
    win      = '0;
    win_req  = '0;
    win_mask = '0;
    win_addr = '0;
    win_din  = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = (32'(last_q) + 32'd1 + k) % NPORT;
      if (!any_req && bus.p_req[2*idx +: 2] != 2'b00) begin
        any_req  = 1'b1;
        win      = GW'(idx);
        win_req  = bus.p_req[2*idx +: 2];
        win_mask = bus.p_mask[2*idx +: 2];
        win_addr = bus.p_addr[32*idx +: 32];
        win_din  = bus.p_din[16*idx +: 16];
      end
    end
  end
`else
  always_comb begin : sel_fixed
    any_req  = 1'b0;
    win      = '0;
    win_req  = '0;
    win_mask = '0;
    win_addr = '0;
    win_din  = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (!any_req && bus.p_req[2*i +: 2] != 2'b00) begin
        any_req  = 1'b1;
        win      = GW'(i);
        win_req  = bus.p_req[2*i +: 2];
        win_mask = bus.p_mask[2*i +: 2];
        win_addr = bus.p_addr[32*i +: 32];
        win_din  = bus.p_din[16*i +: 16];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rd_cnt_q <= '0;
      m_req_q  <= 2'b00;
      m_mask_q <= 2'b11;
      m_addr_q <= '0;
      m_din_q  <= '0;
`ifdef SDRAM_ARB_RR_EN
      last_q   <= GW'(NPORT - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q    <= win;
            m_req_q  <= win_req;
            m_mask_q <= win_mask;
            m_addr_q <= win_addr;
            m_din_q  <= win_din;
            state_q  <= ISSUE;
          end else begin
            m_req_q  <= 2'b00;
          end
        end
        // Command fields stay frozen here: the controller samples the address twice.
        ISSUE: begin
          if (bus.m_ack) begin
            m_req_q <= 2'b00;
`ifdef SDRAM_ARB_RR_EN
            last_q  <= gnt_q;
`endif
            if (m_req_q == 2'b10) begin
              rd_cnt_q <= '0;
              state_q  <= RDATA;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        RDATA: begin
          if (bus.m_valid) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_cnt_q == CW'(BL - 1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.p_ack   = '0;
    bus.p_valid = '0;
    if (state_q == ISSUE) bus.p_ack[gnt_q]   = bus.m_ack;
    if (state_q == RDATA) bus.p_valid[gnt_q] = bus.m_valid;
  end

  assign bus.p_dout = bus.m_dout;
  assign bus.m_req  = m_req_q;
  assign bus.m_mask = m_mask_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_din  = m_din_q;

endmodule
